// File: rtl/axis_kx_byte_packer.sv
// axis_kx_byte_packer
// Collects an 8-bit AXI-Stream byte stream into one wide {k, x} word and
// presents it on a wide AXI-Stream master feeding the matrix-vector
// multiplier's s_axis_kx port. Byte n of a frame lands at bits [8n+7:8n],
// so x (low C*W_X bits) arrives first, then k. Single holding register.
//
// Optional feature (define AXIS_KX_PACKER_TLAST_EN): adds s_axis_tlast and a
// one-cycle err_frame pulse for early or missing end-of-frame markers.
module axis_kx_byte_packer #(
  parameter int R   = 8,
  parameter int C   = 8,
  parameter int W_X = 8,
  parameter int W_K = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tvalid,
  input  logic [7:0]                     s_axis_tdata,
`ifdef AXIS_KX_PACKER_TLAST_EN
  input  logic                           s_axis_tlast,
  output logic                           err_frame,
`endif
  input  logic                           m_axis_kx_tready,
  output logic                           m_axis_kx_tvalid,
  output logic [R*C*W_K + C*W_X - 1:0]   m_axis_kx_tdata
);

  localparam int W_KX = R*C*W_K + C*W_X;
  localparam int NB   = (W_KX + 7) / 8;
  localparam int CW   = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W_KX-1:0] data_q;
  logic            wr_en;
  logic            err_d;
  logic            err_q;

  // Handshake flags are decoded straight from the state register.
  assign s_axis_tready    = (state_q == FILL);
  assign m_axis_kx_tvalid = (state_q == FULL);
  assign m_axis_kx_tdata  = data_q;
  assign wr_en            = s_axis_tvalid && (state_q == FILL);

`ifdef AXIS_KX_PACKER_TLAST_EN
  assign err_frame = err_q;
`endif

  // Next-state, byte counter and framing-error decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (s_axis_tvalid) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = FULL;
`ifdef AXIS_KX_PACKER_TLAST_EN
            // Delivered anyway, but flag the stream as misaligned.
            err_d   = !s_axis_tlast;
`endif
          end else begin
`ifdef AXIS_KX_PACKER_TLAST_EN
            if (s_axis_tlast) begin
              // Early end: drop the partial frame and restart at byte 0.
              cnt_d = '0;
              err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`else
            cnt_d = cnt_q + 1'b1;
`endif
          end
        end
      end
      FULL: begin
        // No byte is taken in the release cycle; FILL resumes next cycle.
        if (m_axis_kx_tready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // State, counter and error-pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rstn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane writes into the holding register; bits at or above W_KX are dropped.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the wide holding register is reset on purpose so tdata is a known zero out of reset.
    if (!rstn) begin
      data_q <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < W_KX; b++) begin
        if (cnt_q == CW'(b / 8)) data_q[b] <= s_axis_tdata[b % 8];
      end
    end
  end

endmodule

// File: tb/tb_axis_kx_byte_packer.sv
// Self-checking bench for axis_kx_byte_packer: default 72-byte build plus an
// odd-width 7-byte instance driven from a vector table.
module tb_axis_kx_byte_packer;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         s_tready;
  logic         s_tvalid = 1'b0;
  logic [7:0]   s_tdata = 8'h00;
  logic         m_tready = 1'b0;
  logic         m_tvalid;
  logic [575:0] m_tdata;

  logic         s2_tready;
  logic         s2_tvalid = 1'b0;
  logic [7:0]   s2_tdata = 8'h00;
  logic         m2_tready = 1'b1;
  logic         m2_tvalid;
  logic [53:0]  m2_tdata;

`ifdef AXIS_KX_PACKER_TLAST_EN
  logic s_tlast = 1'b0;
  logic err_frame;
  logic s2_tlast = 1'b0;
  logic err2_frame;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axis_kx_byte_packer dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_axis_tready    (s_tready),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tdata     (s_tdata),
`ifdef AXIS_KX_PACKER_TLAST_EN
    .s_axis_tlast     (s_tlast),
    .err_frame        (err_frame),
`endif
    .m_axis_kx_tready (m_tready),
    .m_axis_kx_tvalid (m_tvalid),
    .m_axis_kx_tdata  (m_tdata)
  );

  axis_kx_byte_packer #(.R(3), .C(3), .W_X(3), .W_K(5)) dut_small (
    .clk              (clk),
    .rstn             (rstn),
    .s_axis_tready    (s2_tready),
    .s_axis_tvalid    (s2_tvalid),
    .s_axis_tdata     (s2_tdata),
`ifdef AXIS_KX_PACKER_TLAST_EN
    .s_axis_tlast     (s2_tlast),
    .err_frame        (err2_frame),
`endif
    .m_axis_kx_tready (m2_tready),
    .m_axis_kx_tvalid (m2_tvalid),
    .m_axis_kx_tdata  (m2_tdata)
  );

  typedef struct {
    string       name;
    logic [55:0] bytes;  // byte n at [8n+7:8n]
    logic [53:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back 72-byte frame; tlast marks byte 71 when the feature is built.
  task automatic send_frame(input logic [575:0] bytes);
    for (int n = 0; n < 72; n++) begin
      s_tvalid = 1'b1;
      s_tdata  = bytes[8*n +: 8];
`ifdef AXIS_KX_PACKER_TLAST_EN
      s_tlast  = (n == 71);
`endif
      step();
    end
    s_tvalid = 1'b0;
`ifdef AXIS_KX_PACKER_TLAST_EN
    s_tlast  = 1'b0;
`endif
  endtask

  initial begin
    logic [575:0] exp1, exp2, exp3, exp4, mword;
    logic         mfull;
    int           mcnt, words, cyc, bad;

    vecs[0] = '{"small_ones",  56'hFFFFFFFFFFFFFF, 54'h3FFFFFFFFFFFFF};
    vecs[1] = '{"small_ramp",  56'h07060504030201, 54'h07060504030201};
    vecs[2] = '{"small_mixed", 56'hC0A55A00FF1234, 54'h0A55A00FF1234};
    vecs[3] = '{"small_top",   56'h80000000000000, 54'h0};

    for (int n = 0; n < 72; n++) begin
      exp1[8*n +: 8] = 8'(n);
      exp2[8*n +: 8] = 8'(8'h10 + n);
      exp3[8*n +: 8] = 8'(n);
      exp4[8*n +: 8] = 8'(8'hA0 + n);
    end
    exp3[7:0] = 8'hEE;

    // Reset state
    #1;
    check("rst_s_tready", 576'(s_tready), 576'(1));
    check("rst_m_tvalid", 576'(m_tvalid), 576'(0));
    check("rst_m_tdata",  m_tdata, '0);
    step();
    step();
    rstn = 1'b1;
    check("post_rst_s_tready", 576'(s_tready), 576'(1));

    // Frame 0x00..0x47, downstream always ready
    m_tready = 1'b1;
    for (int n = 0; n < 71; n++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(n);
`ifdef AXIS_KX_PACKER_TLAST_EN
      s_tlast  = 1'b0;
`endif
      step();
    end
    check("pre_last_tvalid", 576'(m_tvalid), 576'(0));
    s_tdata = 8'h47;
`ifdef AXIS_KX_PACKER_TLAST_EN
    s_tlast = 1'b1;
`endif
    step();
    s_tvalid = 1'b0;
`ifdef AXIS_KX_PACKER_TLAST_EN
    s_tlast  = 1'b0;
`endif
    check("f1_tvalid",  576'(m_tvalid), 576'(1));
    check("f1_tready",  576'(s_tready), 576'(0));
    check("f1_x",       576'(m_tdata[63:0]), 576'(64'h0706050403020100));
    check("f1_topbyte", 576'(m_tdata[575:568]), 576'(8'h47));
    check("f1_word",    m_tdata, exp1);
    step();
    check("f1_release_tvalid", 576'(m_tvalid), 576'(0));
    check("f1_release_tready", 576'(s_tready), 576'(1));

    // Backpressure: word held for 10 cycles while a byte waits upstream
    m_tready = 1'b0;
    send_frame(exp2);
    check("bp_word", m_tdata, exp2);
    bad = 0;
    s_tvalid = 1'b1;
    s_tdata  = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== exp2) bad++;
    end
    check("bp_hold", 576'(bad), 576'(0));
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    check("bp_release_tready", 576'(s_tready), 576'(1));
    check("bp_release_tvalid", 576'(m_tvalid), 576'(0));
    send_frame(exp3);
    check("bp_next_tvalid", 576'(m_tvalid), 576'(1));
    check("bp_next_word", m_tdata, exp3);
    m_tready = 1'b1;
    step();

    // Random gaps and downstream stalls against an independent model
    mfull = 1'b0;
    mcnt  = 0;
    mword = '0;
    words = 0;
    cyc   = 0;
    bad   = 0;
    while (words < 20 && cyc < 20000) begin
      s_tvalid = 1'($urandom_range(0, 1));
      s_tdata  = 8'($urandom);
      m_tready = 1'($urandom_range(0, 1));
`ifdef AXIS_KX_PACKER_TLAST_EN
      s_tlast  = (mcnt == 71);
`endif
      if (s_tready !== !mfull || m_tvalid !== mfull) bad++;
      if (mfull && m_tready) begin
        check("rand_word", m_tdata, mword);
        words++;
        mfull = 1'b0;
      end else if (!mfull && s_tvalid) begin
        mword[8*mcnt +: 8] = s_tdata;
        if (mcnt == 71) begin
          mcnt  = 0;
          mfull = 1'b1;
        end else begin
          mcnt++;
        end
      end
      step();
      cyc++;
    end
    check("rand_words_done", 576'(words), 576'(20));
    check("rand_protocol", 576'(bad), 576'(0));
    // Drain to a clean FILL state at count 0
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    step();

    // Reset mid-frame after 30 bytes
    for (int n = 0; n < 30; n++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(8'h55 + n);
      step();
    end
    s_tvalid = 1'b0;
    rstn = 1'b0;
    step();
    check("midrst_tvalid", 576'(m_tvalid), 576'(0));
    check("midrst_tdata",  m_tdata, '0);
    rstn = 1'b1;
    step();
    send_frame(exp4);
    check("midrst_word_tvalid", 576'(m_tvalid), 576'(1));
    check("midrst_word", m_tdata, exp4);
    step();
    check("midrst_single_word", 576'(m_tvalid), 576'(0));

    // Odd-width instance: table of 7-byte frames
    for (int v = 0; v < 4; v++) begin
      for (int n = 0; n < 7; n++) begin
        s2_tvalid = 1'b1;
        s2_tdata  = vecs[v].bytes[8*n +: 8];
`ifdef AXIS_KX_PACKER_TLAST_EN
        s2_tlast  = (n == 6);
`endif
        if (n == 6) check({vecs[v].name, "_pre"}, 576'(m2_tvalid), 576'(0));
        step();
      end
      s2_tvalid = 1'b0;
      check({vecs[v].name, "_tvalid"}, 576'(m2_tvalid), 576'(1));
      check({vecs[v].name, "_word"}, 576'(m2_tdata), 576'(vecs[v].exp));
      step();
    end

`ifdef AXIS_KX_PACKER_TLAST_EN
    // Early tlast drops the frame and pulses err_frame once
    for (int n = 0; n <= 40; n++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(n);
      s_tlast  = (n == 40);
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("tlast_err_pulse", 576'(err_frame), 576'(1));
    check("tlast_no_word",   576'(m_tvalid), 576'(0));
    step();
    check("tlast_err_clear", 576'(err_frame), 576'(0));
    check("tlast_still_fill", 576'(s_tready), 576'(1));
    send_frame(exp1);
    check("tlast_clean_tvalid", 576'(m_tvalid), 576'(1));
    check("tlast_clean_err", 576'(err_frame), 576'(0));
    check("tlast_clean_word", m_tdata, exp1);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
